// File: rtl/if_stage_pkg.sv
// Shared fetch/decode constants: reset vector, PC increment and inter-stage bus widths.
// The decoder-side stage wrapper also imports this package.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC        = 32'h1c00_0000;
    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam int          FS_TO_DS_BUS_WD = 64;   // {fs_pc, fs_inst}
    localparam int          BR_BUS_WD       = 33;   // {br_taken, br_target}

    function automatic logic [31:0] seq_pc(input logic [31:0] pc, input logic [31:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's SRAM, decode-handshake and redirect signals.
// The master side is the fetch stage; the slave side is the SRAM/decoder.
interface if_stage_if;

    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    modport master (
        output inst_sram_en,
        output inst_sram_addr,
        input  inst_sram_rdata,
        input  ds_allowin,
        input  br_taken,
        input  br_target,
        output fs_to_ds_valid,
        output fs_pc,
        output fs_inst
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_addr,
        output inst_sram_rdata,
        output ds_allowin,
        output br_taken,
        output br_target,
        input  fs_to_ds_valid,
        input  fs_pc,
        input  fs_inst
    );

endinterface

// File: rtl/if_inst_buf.sv
// One-entry skid buffer holding the SRAM word while decode stalls.
// Clear has priority over capture; the output falls through to live SRAM data when empty.
module if_inst_buf
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        capture_i,
    input  logic        clear_i,
    input  logic [31:0] rdata_i,
    output logic        buf_valid_o,
    output logic [31:0] inst_o
);

    logic        buf_valid_q, buf_valid_d;
    logic [31:0] inst_buf_q,  inst_buf_d;

    always_comb begin
        buf_valid_d = buf_valid_q;
        inst_buf_d  = inst_buf_q;
        if (clear_i) begin
            buf_valid_d = 1'b0;
        end else if (capture_i) begin
            buf_valid_d = 1'b1;
            inst_buf_d  = rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            inst_buf_q  <= 32'h0;
        end else begin
            buf_valid_q <= buf_valid_d;
            inst_buf_q  <= inst_buf_d;
        end
    end

    assign buf_valid_o = buf_valid_q;
    assign inst_o      = buf_valid_q ? inst_buf_q : rdata_i;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency SRAM reads and
// offers {pc, inst} to decode, redirecting on taken branches reported by decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC,
    parameter logic [31:0] PC_STEP  = if_stage_pkg::PC_STEP
) (
    input  logic          clk,
    input  logic          reset,
    if_stage_if.master    bus
);
    import if_stage_pkg::*;

    logic                       fs_valid_q,    fs_valid_d;
    logic [31:0]                fs_pc_q,       fs_pc_d;
    logic                       rdata_fresh_q, rdata_fresh_d;

    logic [BR_BUS_WD-1:0]       br_bus;
    logic                       br_taken;
    logic [31:0]                br_target;
    logic [31:0]                nextpc;
    logic                       fs_ready_go;
    logic                       fs_allowin;
    logic                       sram_en;
    logic                       to_ds_valid;
    logic                       buf_valid;
    logic                       buf_capture;
    logic                       buf_clear;
    logic [31:0]                fs_inst;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

    assign br_bus    = {bus.br_taken, bus.br_target};
    assign br_taken  = br_bus[BR_BUS_WD-1];
    assign br_target = br_bus[31:0];

    // A taken branch always frees the stage: the wrong-path instruction is dropped.
    always_comb begin
        nextpc      = br_taken ? br_target : seq_pc(fs_pc_q, PC_STEP);
        fs_ready_go = buf_valid | rdata_fresh_q;
        fs_allowin  = ~fs_valid_q | (fs_ready_go & bus.ds_allowin) | br_taken;
        sram_en     = ~reset & fs_allowin;
        to_ds_valid = ~reset & fs_valid_q & fs_ready_go & ~br_taken;
        buf_capture = fs_valid_q & rdata_fresh_q & ~buf_valid & ~bus.ds_allowin & ~br_taken;
        buf_clear   = (to_ds_valid & bus.ds_allowin) | br_taken;

        fs_valid_d    = fs_valid_q;
        fs_pc_d       = fs_pc_q;
        rdata_fresh_d = sram_en;
        if (fs_allowin) begin
            fs_valid_d = 1'b1;
            fs_pc_d    = nextpc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q    <= 1'b0;
            fs_pc_q       <= RESET_PC - PC_STEP;
            rdata_fresh_q <= 1'b0;
        end else begin
            fs_valid_q    <= fs_valid_d;
            fs_pc_q       <= fs_pc_d;
            rdata_fresh_q <= rdata_fresh_d;
        end
    end

    if_inst_buf u_inst_buf (
        .clk         (clk),
        .reset       (reset),
        .capture_i   (buf_capture),
        .clear_i     (buf_clear),
        .rdata_i     (bus.inst_sram_rdata),
        .buf_valid_o (buf_valid),
        .inst_o      (fs_inst)
    );

    assign fs_to_ds_bus       = {fs_pc_q, fs_inst};
    assign bus.inst_sram_en   = sram_en;
    assign bus.inst_sram_addr = nextpc;
    assign bus.fs_to_ds_valid = to_ds_valid;
    assign bus.fs_pc          = fs_to_ds_bus[FS_TO_DS_BUS_WD-1:32];
    assign bus.fs_inst        = fs_to_ds_bus[31:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall/skid, redirects, reset and PC wrap.
// The SRAM returns addr ^ A5A5_0000 one cycle after a request and DEAD_BEEF otherwise.
module tb_if_stage;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    if_stage_if bus ();

    if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        bus.inst_sram_rdata <= bus.inst_sram_en ? (bus.inst_sram_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ds_allowin = 1'b1;
        bus.br_taken = 1'b0;
        bus.br_target = 32'h0;
        repeat (3) next_cycle();
        #1;
        n_checks++;
        if ({bus.inst_sram_en, bus.fs_to_ds_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs: en,valid=%b%b want 00", bus.inst_sram_en, bus.fs_to_ds_valid);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.inst_sram_en, bus.inst_sram_addr, bus.fs_to_ds_valid} !== {1'b1, 32'h1c00_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL first_fetch: en=%b addr=%h valid=%b want 1 1c000000 0",
                     bus.inst_sram_en, bus.inst_sram_addr, bus.fs_to_ds_valid);
        end
    endtask

    task automatic test_seq_fetch();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_inst [3];
        exp_pc   = '{32'h1c00_0000, 32'h1c00_0004, 32'h1c00_0008};
        exp_inst = '{32'hb9a5_0000, 32'hb9a5_0004, 32'hb9a5_0008};
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            n_checks++;
            if ({bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst} !== {1'b1, exp_pc[i], exp_inst[i]}) begin
                n_fail++;
                $display("FAIL seq_offer[%0d]: valid=%b pc=%h inst=%h want 1 %h %h",
                         i, bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst, exp_pc[i], exp_inst[i]);
            end
            n_checks++;
            if ({bus.inst_sram_en, bus.inst_sram_addr} !== {1'b1, exp_pc[i] + 32'd4}) begin
                n_fail++;
                $display("FAIL seq_req[%0d]: en=%b addr=%h want 1 %h",
                         i, bus.inst_sram_en, bus.inst_sram_addr, exp_pc[i] + 32'd4);
            end
        end
    endtask

    task automatic test_stall();
        bus.ds_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            #1;
            n_checks++;
            if ({bus.inst_sram_en, bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst} !==
                {1'b0, 1'b1, 32'h1c00_0008, 32'hb9a5_0008}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: en=%b valid=%b pc=%h inst=%h want 0 1 1c000008 b9a50008",
                         i, bus.inst_sram_en, bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst);
            end
        end
        bus.ds_allowin = 1'b1;
        #1;
        n_checks++;
        if ({bus.inst_sram_en, bus.inst_sram_addr} !== {1'b1, 32'h1c00_000c}) begin
            n_fail++;
            $display("FAIL stall_resume_req: en=%b addr=%h want 1 1c00000c", bus.inst_sram_en, bus.inst_sram_addr);
        end
        next_cycle();
        #1;
        n_checks++;
        if ({bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst} !== {1'b1, 32'h1c00_000c, 32'hb9a5_000c}) begin
            n_fail++;
            $display("FAIL stall_resume_offer: valid=%b pc=%h inst=%h want 1 1c00000c b9a5000c",
                     bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst);
        end
    endtask

    task automatic test_branch();
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c00_0100;
        #1;
        n_checks++;
        if ({bus.fs_to_ds_valid, bus.inst_sram_en, bus.inst_sram_addr} !== {1'b0, 1'b1, 32'h1c00_0100}) begin
            n_fail++;
            $display("FAIL branch_squash: valid=%b en=%b addr=%h want 0 1 1c000100",
                     bus.fs_to_ds_valid, bus.inst_sram_en, bus.inst_sram_addr);
        end
        next_cycle();
        bus.br_taken = 1'b0;
        #1;
        n_checks++;
        if ({bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst} !== {1'b1, 32'h1c00_0100, 32'hb9a5_0100}) begin
            n_fail++;
            $display("FAIL branch_target_offer: valid=%b pc=%h inst=%h want 1 1c000100 b9a50100",
                     bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst);
        end
        n_checks++;
        if (bus.inst_sram_addr !== 32'h1c00_0104) begin
            n_fail++;
            $display("FAIL branch_next_req: addr=%h want 1c000104", bus.inst_sram_addr);
        end
    endtask

    task automatic test_branch_stall();
        next_cycle();
        bus.ds_allowin = 1'b0;
        #1;
        n_checks++;
        if ({bus.inst_sram_en, bus.fs_pc} !== {1'b0, 32'h1c00_0104}) begin
            n_fail++;
            $display("FAIL bstall_enter: en=%b pc=%h want 0 1c000104", bus.inst_sram_en, bus.fs_pc);
        end
        next_cycle();
        #1;
        n_checks++;
        if ({bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst} !== {1'b1, 32'h1c00_0104, 32'hb9a5_0104}) begin
            n_fail++;
            $display("FAIL bstall_buffered: valid=%b pc=%h inst=%h want 1 1c000104 b9a50104",
                     bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst);
        end
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c00_0100;
        #1;
        n_checks++;
        if ({bus.fs_to_ds_valid, bus.inst_sram_en, bus.inst_sram_addr} !== {1'b0, 1'b1, 32'h1c00_0100}) begin
            n_fail++;
            $display("FAIL bstall_redirect: valid=%b en=%b addr=%h want 0 1 1c000100",
                     bus.fs_to_ds_valid, bus.inst_sram_en, bus.inst_sram_addr);
        end
        next_cycle();
        bus.br_taken   = 1'b0;
        bus.ds_allowin = 1'b1;
        #1;
        n_checks++;
        if ({bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst} !== {1'b1, 32'h1c00_0100, 32'hb9a5_0100}) begin
            n_fail++;
            $display("FAIL bstall_no_stale: valid=%b pc=%h inst=%h want 1 1c000100 b9a50100",
                     bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst);
        end
    endtask

    task automatic test_reset_mid_stall();
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c00_0040;
        next_cycle();
        bus.br_taken   = 1'b0;
        bus.ds_allowin = 1'b0;
        next_cycle();
        #1;
        n_checks++;
        if ({bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst, bus.inst_sram_en} !==
            {1'b1, 32'h1c00_0040, 32'hb9a5_0040, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_stall_setup: valid=%b pc=%h inst=%h en=%b want 1 1c000040 b9a50040 0",
                     bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst, bus.inst_sram_en);
        end
        reset = 1'b1;
        next_cycle();
        #1;
        n_checks++;
        if ({bus.fs_to_ds_valid, bus.inst_sram_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_stall_during: valid,en=%b%b want 00", bus.fs_to_ds_valid, bus.inst_sram_en);
        end
        reset          = 1'b0;
        bus.ds_allowin = 1'b1;
        #1;
        n_checks++;
        if ({bus.fs_to_ds_valid, bus.inst_sram_en, bus.inst_sram_addr} !== {1'b0, 1'b1, 32'h1c00_0000}) begin
            n_fail++;
            $display("FAIL rst_stall_restart: valid=%b en=%b addr=%h want 0 1 1c000000",
                     bus.fs_to_ds_valid, bus.inst_sram_en, bus.inst_sram_addr);
        end
        next_cycle();
        #1;
        n_checks++;
        if ({bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst} !== {1'b1, 32'h1c00_0000, 32'hb9a5_0000}) begin
            n_fail++;
            $display("FAIL rst_stall_first_offer: valid=%b pc=%h inst=%h want 1 1c000000 b9a50000",
                     bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst);
        end
    endtask

    task automatic test_wrap();
        bus.br_taken  = 1'b1;
        bus.br_target = 32'hffff_fffc;
        next_cycle();
        bus.br_taken = 1'b0;
        #1;
        n_checks++;
        if ({bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst, bus.inst_sram_addr} !==
            {1'b1, 32'hffff_fffc, 32'h5a5a_fffc, 32'h0000_0000}) begin
            n_fail++;
            $display("FAIL wrap_top: valid=%b pc=%h inst=%h addr=%h want 1 fffffffc 5a5afffc 00000000",
                     bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst, bus.inst_sram_addr);
        end
        next_cycle();
        #1;
        n_checks++;
        if ({bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst, bus.inst_sram_addr} !==
            {1'b1, 32'h0000_0000, 32'ha5a5_0000, 32'h0000_0004}) begin
            n_fail++;
            $display("FAIL wrap_zero: valid=%b pc=%h inst=%h addr=%h want 1 00000000 a5a50000 00000004",
                     bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst, bus.inst_sram_addr);
        end
    endtask

    task automatic test_misaligned_target();
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c00_0102;
        #1;
        n_checks++;
        if (bus.inst_sram_addr !== 32'h1c00_0102) begin
            n_fail++;
            $display("FAIL misalign_req: addr=%h want 1c000102", bus.inst_sram_addr);
        end
        next_cycle();
        bus.br_taken = 1'b0;
        #1;
        n_checks++;
        if ({bus.fs_pc, bus.fs_inst, bus.inst_sram_addr} !== {32'h1c00_0102, 32'hb9a5_0102, 32'h1c00_0106}) begin
            n_fail++;
            $display("FAIL misalign_offer: pc=%h inst=%h addr=%h want 1c000102 b9a50102 1c000106",
                     bus.fs_pc, bus.fs_inst, bus.inst_sram_addr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_seq_fetch();
        test_stall();
        test_branch();
        test_branch_stall();
        test_reset_mid_stall();
        test_wrap();
        test_misaligned_target();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the combinational decoder.
- Owns the PC and drives a synchronous instruction SRAM with 1-cycle read latency.
- Holds the returned instruction in a 1-entry skid buffer while decode stalls.
- Delivers {pc, inst} to decode under a valid/allowin handshake and redirects on taken branches/jumps reported by decode.

Parameters:
- RESET_PC, 32'h1c00_0000, address of the first instruction fetched after reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  stage clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- inst_sram_en  output  1  read request this cycle.
- inst_sram_addr  output  32  read address (= nextpc).
- inst_sram_rdata  input  32  read data; valid exactly one cycle after inst_sram_en.
- ds_allowin  input  1  decode can accept an instruction this cycle.
- br_taken  input  1  one-cycle pulse from decode: the instruction decode is accepting this cycle redirects control flow.
- br_target  input  32  redirect address; valid when br_taken=1.
- fs_to_ds_valid  output  1  {fs_pc, fs_inst} valid toward decode.
- fs_pc  output  32  PC of the offered instruction.
- fs_inst  output  32  offered instruction word.

Behaviour:
- State: fs_valid, fs_pc, rdata_fresh (registered inst_sram_en), inst_buf, inst_buf_valid.
- Reset values:
  - fs_valid=0, fs_pc=RESET_PC-PC_STEP, rdata_fresh=0, inst_buf_valid=0, inst_buf=0.
  - Outputs while reset=1: inst_sram_en=0, fs_to_ds_valid=0.
- Pre-IF:
  - nextpc = br_taken ? br_target : fs_pc+PC_STEP, 32-bit wrap, no overflow detection.
  - inst_sram_addr = nextpc at all times.
- Handshake:
  - fs_ready_go = inst_buf_valid | rdata_fresh.
  - fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken.
  - inst_sram_en = ~reset & fs_allowin.
- Fetch update: on fs_allowin & ~reset, fs_valid<=1 and fs_pc<=nextpc.
- First fetch: in the first cycle after reset deasserts, inst_sram_addr=RESET_PC and inst_sram_en=1. The next cycle, fs_valid=1, fs_pc=RESET_PC, and rdata is fresh.
- Output:
  - fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken.
  - fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
- Skid buffer:
  - Capture: if fs_valid & rdata_fresh & ~inst_buf_valid & ~ds_allowin & ~br_taken, then inst_buf<=inst_sram_rdata and inst_buf_valid<=1.
  - Clear: inst_buf_valid clears on a fs_to_ds handshake (fs_to_ds_valid & ds_allowin), on br_taken, or on reset.
  - While stalled, no new SRAM request is issued, so the SRAM output is never relied on after the first returned cycle.
- Branch redirect (br_taken=1):
  - The wrong-path instruction in IF is squashed: fs_to_ds_valid=0 that cycle and the buffer is cleared.
  - A request for br_target is issued the same cycle.
  - Next cycle: fs_pc=br_target, rdata fresh.
  - br_taken overrides a simultaneous decode stall.
- Throughput: 1 instruction/cycle when ds_allowin stays 1. Redirect penalty is 1 bubble.
- Reset mid-stall or mid-redirect: all state returns to reset values at the next edge and fetch restarts at RESET_PC.
- No misalignment check: br_target[1:0] is passed through to the address unchanged. Exceptions are out of scope.

Decomposition:
- Shared package:
  - RESET_PC
  - PC_STEP
  - FS_TO_DS_BUS_WD=64 ({fs_pc, fs_inst})
  - BR_BUS_WD=33 ({br_taken, br_target})
  - Reused by the decoder-side stage wrapper.
- Sub-module: if_inst_buf, a 1-entry skid buffer with capture/clear/data mux. Everything else stays in if_stage.

Test Plan:
- Reset 3 cycles, then release, ds_allowin=1, SRAM model returns mem[addr] = addr ^ 32'hA5A5_0000 → addresses 1c000000, 1c000004, 1c000008 requested on consecutive cycles; fs_to_ds_valid=1 from cycle 2 with matching pc/inst.
- Steady fetch, drop ds_allowin for 3 cycles at pc=1c000008 → inst_sram_en=0 during the stall; fs_pc and fs_inst held at 1c000008 / its word; resume with no skip or duplicate.
- br_taken=1 with br_target=1c000100 while IF holds 1c00000c → fs_to_ds_valid=0 that cycle; next cycle fs_pc=1c000100 with the correct inst; 1c00000c never handed over.
- br_taken coincident with a stall and a valid buffer → buffer cleared, address 1c000100 requested, no stale buffered instruction delivered.
- Assert reset mid-stall at pc=1c000040 → next cycle fs_to_ds_valid=0, inst_sram_en=0; after release the first address is 1c000000.
- fs_pc=ffff_fffc sequential → next address 0000_0000 (wrap).
